// File: rtl/gen_fifo_wr_arbiter_if.sv
// Bundle between the requesters, the burst arbiter and the async FIFO write
// controller. Everything here lives in the FIFO write-clock domain.
//   req_vld/req_len/req_gnt : burst request (len = beats-1), one-hot grant pulse
//   wr_data/wr_vld/wr_rdy   : per-requester data beats
//   faw_depth/faw_full      : write-side FIFO status from the write controller
//   push/push_data          : push strobe and RAM write data to the FIFO
//   cur_owner/arb_busy      : arbiter status
// master = requester/FIFO side, slave = arbiter.
interface gen_fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 4,
    parameter int LEN_WIDTH  = 4
);
    logic [NUM_REQ-1:0]                 req_vld;
    logic [NUM_REQ-1:0][LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]                 req_gnt;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wr_data;
    logic [NUM_REQ-1:0]                 wr_vld;
    logic [NUM_REQ-1:0]                 wr_rdy;
    logic [PTR_WIDTH:0]                 faw_depth;
    logic                               faw_full;
    logic                               push;
    logic [DATA_WIDTH-1:0]              push_data;
    logic [2:0]                         cur_owner;
    logic                               arb_busy;

    modport master (
        output req_vld, req_len, wr_data, wr_vld, faw_depth, faw_full,
        input  req_gnt, wr_rdy, push, push_data, cur_owner, arb_busy
    );

    modport slave (
        input  req_vld, req_len, wr_data, wr_vld, faw_depth, faw_full,
        output req_gnt, wr_rdy, push, push_data, cur_owner, arb_busy
    );
endinterface

// File: rtl/gen_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ
// requesters. A requester is granted only when the FIFO has room for its whole
// burst, then owns the port until its last beat is pushed.
// Ports:
//   wclk   : write clock
//   wreset : synchronous active-high reset
//   bus    : gen_fifo_wr_arbiter_if slave modport (requests, beats, FIFO status,
//            push strobe/data, owner/busy status)
module gen_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                 wclk,
    input  logic                 wreset,
    gen_fifo_wr_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Space-check width: wide enough that depth + len + 1 never wraps.
    localparam int SW = ((PTR_WIDTH > LEN_WIDTH) ? PTR_WIDTH : LEN_WIDTH) + 2;
    localparam logic [SW-1:0] CAP = SW'(1) << PTR_WIDTH;

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         owner_q, last_q, cand;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic [NUM_REQ-1:0]    gnt_q, rdy;
    logic                  cand_found, elig, grant, push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [SW-1:0]         need;
    logic [IW:0]           pos;

    // Strict round-robin scan starting just after the last owner. Only the
    // first requesting index is considered; if it lacks space nobody else is
    // granted, so a long burst cannot be starved by short ones.
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        pos        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, last_q} + (IW+1)'(k + 1);
            if (pos >= (IW+1)'(NUM_REQ))
                pos = pos - (IW+1)'(NUM_REQ);
            if (!cand_found && bus.req_vld[pos[IW-1:0]]) begin
                cand_found = 1'b1;
                cand       = pos[IW-1:0];
            end
        end
    end

    // Pessimistic: faw_depth lags read-side pops, never over-reports space.
    assign need  = SW'(bus.faw_depth) + SW'(bus.req_len[cand]) + SW'(1);
    assign elig  = (need <= CAP);
    assign grant = (state_q == IDLE) && cand_found && elig;

    // FSM state register
    always_ff @(posedge wclk) begin
        if (wreset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state. Leaving XFER always passes through one IDLE cycle so
    // faw_depth has caught up with the last burst before the next check.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = XFER;
            XFER:    if (push && cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs. Reset gates rdy/push combinationally so a burst cut by
    // reset pushes nothing in the reset cycle.
    always_comb begin
        rdy = '0;
        if (state_q == XFER && !bus.faw_full && !wreset)
            rdy[owner_q] = 1'b1;
        push      = |(rdy & bus.wr_vld);
        push_data = push ? bus.wr_data[owner_q] : '0;
    end

    // Owner / beat count / grant pulse
    always_ff @(posedge wclk) begin
        if (wreset) begin
            owner_q <= IW'(NUM_REQ - 1);
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            gnt_q <= '0;
            if (grant) begin
                owner_q     <= cand;
                cnt_q       <= bus.req_len[cand];
                gnt_q[cand] <= 1'b1;
            end else if (push) begin
                if (cnt_q == '0) last_q <= owner_q;
                else             cnt_q  <= cnt_q - LEN_WIDTH'(1);
            end
        end
    end

    assign bus.req_gnt   = gnt_q;
    assign bus.wr_rdy    = rdy;
    assign bus.push      = push;
    assign bus.push_data = push_data;
    assign bus.cur_owner = 3'(owner_q);
    assign bus.arb_busy  = (state_q == XFER);
endmodule

// File: tb/tb_gen_fifo_wr_arbiter.sv
module tb_gen_fifo_wr_arbiter;
    localparam int NUM_REQ = 2, DW = 32, PW = 4, LW = 4;

    logic wclk = 1'b0;
    logic wreset;
    int   nchk = 0;
    int   nerr = 0;

    gen_fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .PTR_WIDTH(PW), .LEN_WIDTH(LW)) bus ();

    gen_fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .PTR_WIDTH(PW), .LEN_WIDTH(LW)) dut (
        .wclk   (wclk),
        .wreset (wreset),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge wclk);
        #1;
    endtask

    task automatic expect_grant(input logic r);
        #1;
        chk("gnt", 32'(bus.req_gnt), (r ? 32'd2 : 32'd1));
        chk("busy_gnt", 32'(bus.arb_busy), 1);
        chk("owner", 32'(bus.cur_owner), 32'(r));
    endtask

    // Runs beats from the current (XFER) cycle until n pushes; the other
    // requester keeps wr_vld high to show it is ignored.
    task automatic do_beats(input logic r, input int n, input bit tog, input logic [31:0] base);
        int pushed = 0;
        int cyc    = 0;
        bit v      = 1'b1;
        while (pushed < n && cyc < 4 * n + 4) begin
            bus.wr_vld     = '0;
            bus.wr_vld[~r] = 1'b1;
            bus.wr_vld[r]  = v;
            bus.wr_data[r]  = base + 32'(pushed);
            bus.wr_data[~r] = 32'hdead0000 + 32'(cyc);
            #1;
            chk("busy", 32'(bus.arb_busy), 1);
            chk("push", 32'(bus.push), 32'(v));
            chk("pdata", bus.push_data, v ? base + 32'(pushed) : 32'd0);
            chk("rdy_other", 32'(bus.wr_rdy[~r]), 0);
            if (v) pushed++;
            v = tog ? ~v : 1'b1;
            tick;
            cyc++;
        end
        chk("beats", 32'(pushed), 32'(n));
        bus.wr_vld = '0;
        #1;
        chk("busy_end", 32'(bus.arb_busy), 0);
    endtask

    initial begin
        wreset        = 1'b1;
        bus.req_vld   = '0;
        bus.req_len   = '0;
        bus.wr_data   = '0;
        bus.wr_vld    = 2'b11;
        bus.faw_depth = '0;
        bus.faw_full  = 1'b0;
        tick;
        tick;
        // reset state
        chk("rst_push", 32'(bus.push), 0);
        chk("rst_rdy", 32'(bus.wr_rdy), 0);
        chk("rst_gnt", 32'(bus.req_gnt), 0);
        chk("rst_busy", 32'(bus.arb_busy), 0);
        chk("rst_owner", 32'(bus.cur_owner), 1);

        // alternating single-beat bursts 0,1,0,1 with a dead cycle between
        wreset         = 1'b0;
        bus.req_vld    = 2'b11;
        bus.wr_data[0] = 32'hA0;
        bus.wr_data[1] = 32'hB1;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("alt_idle_gnt", 32'(bus.req_gnt), 0);
            chk("alt_idle_push", 32'(bus.push), 0);
            chk("alt_idle_busy", 32'(bus.arb_busy), 0);
            tick;
            chk("alt_gnt", 32'(bus.req_gnt), (b % 2 == 0) ? 32'd1 : 32'd2);
            chk("alt_push", 32'(bus.push), 1);
            chk("alt_pdata", bus.push_data, (b % 2 == 0) ? 32'hA0 : 32'hB1);
            chk("alt_rdy", 32'(bus.wr_rdy), (b % 2 == 0) ? 32'd1 : 32'd2);
            tick;
        end

        // depth 12 + 4 beats exactly fills 16 entries
        bus.wr_vld     = '0;
        bus.req_vld    = 2'b01;
        bus.req_len[0] = 4'd3;
        bus.faw_depth  = 5'd12;
        tick;
        expect_grant(1'b0);
        bus.req_vld = '0;
        do_beats(1'b0, 4, 1'b0, 32'd100);

        // req1, 8 beats with wr_vld toggling
        bus.faw_depth  = '0;
        bus.req_vld    = 2'b10;
        bus.req_len[1] = 4'd7;
        tick;
        expect_grant(1'b1);
        bus.req_vld = '0;
        do_beats(1'b1, 8, 1'b1, 32'd200);

        // depth 13: req0 (top) lacks room and blocks req1
        bus.req_vld    = 2'b11;
        bus.req_len[0] = 4'd3;
        bus.req_len[1] = 4'd0;
        bus.faw_depth  = 5'd13;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("blk_gnt", 32'(bus.req_gnt), 0);
            chk("blk_busy", 32'(bus.arb_busy), 0);
            tick;
        end
        bus.faw_depth = 5'd12;
        tick;
        expect_grant(1'b0);
        bus.req_vld = '0;
        do_beats(1'b0, 4, 1'b0, 32'd300);

        // faw_full stalls req1's 3-beat burst after one beat
        bus.faw_depth  = '0;
        bus.req_vld    = 2'b10;
        bus.req_len[1] = 4'd2;
        tick;
        expect_grant(1'b1);
        bus.req_vld    = '0;
        bus.wr_vld     = 2'b10;
        bus.wr_data[1] = 32'd400;
        #1;
        chk("full_pre_push", 32'(bus.push), 1);
        chk("full_pre_pdata", bus.push_data, 32'd400);
        tick;
        bus.faw_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("full_rdy", 32'(bus.wr_rdy), 0);
            chk("full_push", 32'(bus.push), 0);
            chk("full_busy", 32'(bus.arb_busy), 1);
            tick;
        end
        bus.faw_full = 1'b0;
        do_beats(1'b1, 2, 1'b0, 32'd401);

        // reset after 3 of 8 beats
        bus.req_vld    = 2'b01;
        bus.req_len[0] = 4'd7;
        tick;
        expect_grant(1'b0);
        bus.req_vld = '0;
        bus.wr_vld  = 2'b01;
        for (int k = 0; k < 3; k++) begin
            bus.wr_data[0] = 32'd500 + 32'(k);
            #1;
            chk("pre_rst_push", 32'(bus.push), 1);
            tick;
        end
        wreset = 1'b1;
        #1;
        chk("rstcyc_push", 32'(bus.push), 0);
        chk("rstcyc_rdy", 32'(bus.wr_rdy), 0);
        tick;
        wreset         = 1'b0;
        bus.req_vld    = 2'b11;
        bus.req_len[0] = 4'd0;
        bus.req_len[1] = 4'd0;
        #1;
        chk("post_rst_busy", 32'(bus.arb_busy), 0);
        chk("post_rst_owner", 32'(bus.cur_owner), 1);
        chk("post_rst_gnt", 32'(bus.req_gnt), 0);
        chk("post_rst_push", 32'(bus.push), 0);
        tick;
        expect_grant(1'b0);
        chk("post_rst_beat", 32'(bus.push), 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/gen_fifo_wr_arbiter.md
Name: gen_fifo_wr_arbiter

Overview:
- Round-robin burst arbiter that shares the write port of one gen_fifo_async_wrctl instance among NUM_REQ requesters, all in the FIFO write-clock domain.
- A requester gets the port only when the write-side depth shows room for its whole burst. It then holds the port until its last beat is pushed.
- Output push/push_data drive the write controller's push input and the RAM write data. faw_depth/faw_full come back from the write controller.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, write data width
PTR_WIDTH, 4, FIFO pointer width; capacity = 2^PTR_WIDTH entries
LEN_WIDTH, 4, burst length field width; must be <= PTR_WIDTH

Ports:
wclk  input  1  write clock; the only clock
wreset  input  1  reset, synchronous, active-high
req_vld  input  NUM_REQ  per-requester burst request; held until grant, may be withdrawn before grant
req_len  input  NUM_REQ*LEN_WIDTH  per-requester burst length minus 1, slice i = [i*LEN_WIDTH +: LEN_WIDTH]
req_gnt  output  NUM_REQ  one-cycle grant pulse, one-hot
wr_data  input  NUM_REQ*DATA_WIDTH  per-requester write data
wr_vld  input  NUM_REQ  per-requester data beat valid
wr_rdy  output  NUM_REQ  per-requester data beat ready
faw_depth  input  PTR_WIDTH+1  write-side FIFO depth
faw_full  input  1  write-side FIFO full
push  output  1  FIFO push strobe
push_data  output  DATA_WIDTH  FIFO write data
cur_owner  output  3  index of current/last owner
arb_busy  output  1  high while in XFER

Behaviour:
- Reset: wreset is sampled on the wclk rising edge. After reset:
  - state=IDLE, req_gnt=0, arb_busy=0, beat count=0.
  - last owner=NUM_REQ-1, so requester 0 has top priority after reset.
  - cur_owner=NUM_REQ-1.
- Reset cycle gating: push and wr_rdy are forced to 0 combinationally while wreset=1. This holds even if reset arrives mid-burst. A burst aborted by reset is dropped; no further beats are pushed.
- States are IDLE and XFER.
- IDLE, candidate selection:
  - Candidate = first i with req_vld[i]=1, scanning from (last owner+1) mod NUM_REQ upward with wrap.
  - The scan is strict: an ineligible top candidate blocks all others. No skipping, so long bursts are never starved.
- IDLE, space check:
  - The candidate is eligible when faw_depth + req_len[i] + 1 <= 2^PTR_WIDTH.
  - Computed at width max(PTR_WIDTH, LEN_WIDTH)+2 so it cannot overflow.
  - The check is pessimistic by design: faw_depth lags read-side pops.
- IDLE -> XFER when the candidate is eligible. On the next edge:
  - owner := i, cur_owner := i.
  - beat count := req_len[i], sampled only here.
  - req_gnt[i]=1 for exactly that first XFER cycle.
- No candidate: stay in IDLE, no grant.
- XFER, handshake and push:
  - wr_rdy[owner] = ~faw_full & ~wreset. All other wr_rdy bits are 0.
  - push = wr_vld[owner] & wr_rdy[owner].
  - push_data = wr_data[owner] when push=1, otherwise 0.
  - Combinational path from wr_vld to push is zero latency. A beat may be pushed in the grant cycle.
- XFER, beat counting:
  - Each push decrements beat count.
  - A push with beat count=0 is the last beat. On the next edge: state := IDLE, last owner := owner.
- Dead cycle: at least one IDLE cycle separates bursts. This guarantees faw_depth, registered one cycle after push, includes the previous burst before the next space check.
- Gaps: wr_vld=0 in XFER holds the state indefinitely; there is no timeout.
- Full flag: with the reservation, faw_full is never expected during XFER. It still gates wr_rdy as protection.
- Other requesters: wr_vld from non-owners is ignored. req_vld changes during XFER have no effect until IDLE.
- Length limit: req_len max (2^LEN_WIDTH)-1 always fits in an empty FIFO, since LEN_WIDTH <= PTR_WIDTH.
- arb_busy = (state==XFER).

Test Plan:
- Reset release, req_vld=2'b11, req_len=0,0, wr_vld=11, faw_depth=0:
  - req_gnt=01 in cycle 1, push 1 beat of wr_data[0], one IDLE cycle.
  - Then req_gnt=10, push wr_data[1].
  - Alternation continues 0,1,0,1.
- PTR_WIDTH=4, faw_depth=12, req0 req_len=3:
  - Grant, then 4 pushes, return to IDLE.
- faw_depth=13, req0 req_len=3:
  - No grant.
  - Req1 with req_len=0 is pending at lower priority: also no grant (strict RR).
  - Drop faw_depth to 12: req0 is granted.
- Owner req1, req_len=7, wr_vld toggling 1,0,1,...:
  - Exactly 8 pushes, push_data matches wr_data[1] in order.
  - wr_rdy[0]=0 throughout.
  - arb_busy drops the cycle after the 8th push.
- faw_full forced 1 during XFER:
  - wr_rdy=0, push=0, beat count held.
  - Release: burst completes with the correct count.
- wreset=1 after 3 of 8 beats:
  - push=0 in the reset cycle, state IDLE, cur_owner=NUM_REQ-1.
  - The next grant goes to requester 0.
